// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor.
// Subtraction adds the nines complement of B; one digit per cycle, LSD first.
module bcd_serial_addsub #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NDIGITS-1:0]   A,
  input  logic [4*NDIGITS-1:0]   B,
  input  logic                   cin,
  output logic [4*NDIGITS-1:0]   S,
  output logic                   Cout,
  output logic                   busy,
  output logic                   done,
  output logic                   invalid
);

  localparam int W  = 4 * NDIGITS;
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic            r_sub;
  logic            r_carry;
  logic [IW-1:0]   r_idx;

  logic [3:0]      w_a_dig;
  logic [3:0]      w_b_raw;
  logic [3:0]      w_b_dig;
  logic [4:0]      w_t;
  logic            w_carry;
  logic [3:0]      w_dig;
  logic            w_last;
  logic            w_inv;
  logic [W-1:0]    w_acc_next;

  always_comb begin
    w_a_dig = r_a[4*int'(r_idx) +: 4];
    w_b_raw = r_b[4*int'(r_idx) +: 4];
    w_b_dig = r_sub ? (4'd9 - w_b_raw) : w_b_raw;
    w_t     = {1'b0, w_a_dig} + {1'b0, w_b_dig}
            + {4'b0, r_carry};
    w_carry = (w_t > 5'd9);
    w_dig   = w_carry ? (w_t[3:0] + 4'd6) : w_t[3:0];
    w_last  = (r_idx == IW'(NDIGITS - 1));
    w_acc_next = r_acc;
    w_acc_next[4*int'(r_idx) +: 4] = w_dig;
  end

  // Flag reflects the raw latched operands, not the complemented B.
  always_comb begin
    w_inv = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_a[4*i +: 4] > 4'd9 || r_b[4*i +: 4] > 4'd9)
        w_inv = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_sub   <= sub;
            r_carry <= sub ? ~cin : cin;
            r_idx   <= '0;
            r_acc   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_carry;
          if (w_last) begin
            S       <= w_acc_next;
            Cout    <= w_carry;
            invalid <= w_inv;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: decimal-arithmetic model,
// per-cycle output compare, directed and random operations.
module tb_bcd_serial_addsub;

  localparam int N = 4;
  localparam int P = 10 ** N;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        i;
  } res_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic        cin;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] S;
  logic        Cout;
  logic        busy;
  logic        done;
  logic        invalid;

  int n_vec = 0;
  int n_err = 0;

  bcd_serial_addsub #(.NDIGITS(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .sub     (sub),
    .A       (A),
    .B       (B),
    .cin     (cin),
    .S       (S),
    .Cout    (Cout),
    .busy    (busy),
    .done    (done),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  // Valid operands: plain decimal arithmetic; A-B-c is offset by 10^N
  // so "no borrow" shows up as the carry. Invalid digits: per-digit rule.
  function automatic res_t model(input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic s,
                                 input logic c);
    res_t r;
    int va, vb, v;
    logic [3:0] da, db, dd;
    logic [4:0] t;
    logic cy;
    r = '0;
    va = 0;
    vb = 0;
    for (int k = N - 1; k >= 0; k--) begin
      da = a[4*k +: 4];
      db = b[4*k +: 4];
      if (da > 9 || db > 9) r.i = 1'b1;
      va = va * 10 + int'(da);
      vb = vb * 10 + int'(db);
    end
    if (!r.i) begin
      if (!s) v = va + vb + int'(c);
      else    v = va - vb - int'(c) + P;
      r.c = (v >= P);
      v = v % P;
      for (int k = 0; k < N; k++) begin
        r.s[4*k +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end else begin
      cy = s ? ~c : c;
      for (int k = 0; k < N; k++) begin
        da = a[4*k +: 4];
        db = s ? (4'd9 - b[4*k +: 4]) : b[4*k +: 4];
        t  = {1'b0, da} + {1'b0, db} + {4'b0, cy};
        if (t > 9) begin
          dd = t[3:0] + 4'd6;
          cy = 1'b1;
        end else begin
          dd = t[3:0];
          cy = 1'b0;
        end
        r.s[4*k +: 4] = dd;
      end
      r.c = cy;
    end
    return r;
  endfunction

  // Cycle model: m_left counts cycles until the block is idle again.
  int   m_left = 0;
  res_t m_out  = '0;
  res_t m_pend = '0;
  bit   chk_en = 1'b0;

  always @(posedge clk) begin
    chk_en <= 1'b1;
    if (reset) begin
      m_left <= 0;
      m_out  <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend <= model(A, B, sub, cin);
        m_left <= N + 1;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_out <= m_pend;
    end
  end

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 16'(busy), 16'(m_left > 1));
      chk("done", 16'(done), 16'(m_left == 1));
      chk("S", S, m_out.s);
      chk("Cout", 16'(Cout), 16'(m_out.c));
      chk("invalid", 16'(invalid), 16'(m_out.i));
    end
  end

  task automatic lit(input string nm, input res_t got, input res_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got S=%h C=%b I=%b expected S=%h C=%b I=%b",
               nm, got.s, got.c, got.i, exp.s, exp.c, exp.i);
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b,
                    input logic s, input logic c,
                    output res_t r, output int nbusy, output int lat);
    bit ok;
    @(negedge clk);
    A = a; B = b; sub = s; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    nbusy = 0;
    lat = 0;
    r = '0;
    for (int i = 0; i < N + 4; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ok  = 1'b1;
        lat = i + 1;
        r   = {S, Cout, invalid};
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL op_timeout: got no done expected done");
    end
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  function automatic logic [15:0] rnd_bcd();
    logic [15:0] v;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 19) == 0)
        v[4*k +: 4] = 4'($urandom_range(10, 15));
      else
        v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    res_t r;
    int nb, lat, nd;
    bit rst_op;

    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0;
    A = '0; B = '0;
    repeat (2) @(negedge clk);
    lit("reset_out", {S, Cout, invalid}, '0);
    chk("reset_busy_done", {14'b0, busy, done}, 16'h0);
    reset = 1'b0;

    lit("model_add", model(16'h1234, 16'h5678, 1'b0, 1'b0),
        {16'h6912, 1'b0, 1'b0});
    lit("model_sub", model(16'h0100, 16'h0001, 1'b1, 1'b1),
        {16'h0098, 1'b1, 1'b0});
    lit("model_inv", model(16'h00A3, 16'h0001, 1'b0, 1'b0),
        {16'h0104, 1'b0, 1'b1});

    op(16'h1234, 16'h5678, 1'b0, 1'b0, r, nb, lat);
    lit("add_1234_5678", r, {16'h6912, 1'b0, 1'b0});
    chk("busy_cycles", 16'(nb), 16'(N));
    chk("done_latency", 16'(lat), 16'(N + 1));

    op(16'h9999, 16'h0001, 1'b0, 1'b0, r, nb, lat);
    lit("ripple_9999", r, {16'h0000, 1'b1, 1'b0});
    op(16'h0009, 16'h0000, 1'b0, 1'b0, r, nb, lat);
    lit("nine_nocorr", r, {16'h0009, 1'b0, 1'b0});
    op(16'h0005, 16'h0007, 1'b1, 1'b0, r, nb, lat);
    lit("sub_5_7", r, {16'h9998, 1'b0, 1'b0});
    op(16'h0100, 16'h0001, 1'b1, 1'b1, r, nb, lat);
    lit("sub_100_1_b", r, {16'h0098, 1'b1, 1'b0});
    op(16'h00A3, 16'h0001, 1'b0, 1'b0, r, nb, lat);
    lit("invalid_a3", r, {16'h0104, 1'b0, 1'b1});
    op(16'h0001, 16'h0001, 1'b0, 1'b0, r, nb, lat);
    lit("invalid_clr", r, {16'h0002, 1'b0, 1'b0});

    // Abort with reset in the second RUN cycle.
    @(negedge clk);
    A = 16'h4444; B = 16'h3333; sub = 1'b0; cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_done(N + 4, nd);
    chk("abort_no_done", 16'(nd), 16'd0);
    lit("abort_out", {S, Cout, invalid}, '0);

    // Start pulsed while running is dropped.
    @(negedge clk);
    A = 16'h0250; B = 16'h0750; sub = 1'b0; cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 16'h1111; B = 16'h1111; sub = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_done(N + 6, nd);
    chk("ignore_start", 16'(nd), 16'd1);
    lit("ignore_out", {S, Cout, invalid}, {16'h1000, 1'b0, 1'b0});

    for (int it = 0; it < 300; it++) begin
      rst_op = ($urandom_range(0, 24) == 0);
      @(negedge clk);
      A = rnd_bcd(); B = rnd_bcd();
      sub = 1'($urandom); cin = 1'($urandom);
      start = 1'b1;
      for (int j = 0; j <= N + 1; j++) begin
        @(negedge clk);
        start = (j < N) && ($urandom_range(0, 3) == 0);
        reset = rst_op && (j == 1);
        if ($urandom_range(0, 1) == 1) begin
          A = 16'($urandom); B = 16'($urandom);
          sub = 1'($urandom); cin = 1'($urandom);
        end
      end
      start = 1'b0;
      reset = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (N + 3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 The block SHALL have parameter NDIGITS, default 4, giving the number of BCD digits per operand (legal range 1-16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to begin an operation; it is sampled only in IDLE.
REQ-005 The block SHALL have port sub, input, 1, the mode: 0 computes A+B+cin, 1 computes A-B-cin.
REQ-006 The block SHALL have ports A and B, input, 4*NDIGITS each, packed BCD operands with digit 0 at bits [3:0].
REQ-007 The block SHALL have port cin, input, 1, carry-in for add and borrow-in for subtract.
REQ-008 The block SHALL have port S, output, 4*NDIGITS, the registered BCD result.
REQ-009 The block SHALL have port Cout, output, 1: in add mode the decimal carry-out; in subtract mode 1 means no borrow (A >= B+cin).
REQ-010 The block SHALL have port busy, output, 1, high while the state is RUN.
REQ-011 The block SHALL have port done, output, 1, a single-cycle pulse when S, Cout and invalid are updated.
REQ-012 The block SHALL have port invalid, output, 1, set when any latched A or B digit exceeds 9.

Function
REQ-013 The state machine SHALL have states IDLE, RUN and DONE.
REQ-014 Transitions SHALL be: IDLE->RUN on start=1; RUN->DONE after NDIGITS digit cycles; DONE->IDLE unconditionally after 1 cycle.
REQ-015 On the IDLE->RUN edge the block SHALL latch A, B, sub and cin, clear the digit index to 0 and set the internal carry to cin (add) or ~cin (subtract).
REQ-016 In subtract mode each B digit SHALL be replaced by its nines complement (9-d, computed 4-bit modulo 16) before addition.
REQ-017 For each RUN cycle, digit i SHALL be computed as t = a_i + b'_i + carry (5-bit); if t > 9, digit = (t+6)[3:0] and carry = 1; otherwise digit = t[3:0] and carry = 0.
REQ-018 A sum of exactly 9 SHALL NOT be corrected (digit 9, carry 0).
REQ-019 One digit SHALL be processed per RUN cycle, least-significant first; the digit index wraps to 0 only through IDLE.
REQ-020 The latency from the start-accept edge to the done pulse SHALL be NDIGITS+1 cycles.
REQ-021 S, Cout and invalid SHALL update only on the RUN->DONE edge and SHALL hold their values until the next done or reset.
REQ-022 done SHALL be high exactly during DONE; busy SHALL be high exactly during RUN.
REQ-023 start SHALL be ignored in RUN and DONE; no queuing.
REQ-024 Inputs A, B, sub and cin changing during RUN SHALL have no effect on the result.
REQ-025 When invalid=1, S and Cout SHALL still be produced by the REQ-017 rule on the raw digits, without saturation or clamping.

Reset
REQ-026 When reset=1 on a clock edge, the state SHALL become IDLE and S=0, Cout=0, done=0, busy=0, invalid=0; the index and carry SHALL clear.
REQ-027 Reset during RUN or DONE SHALL abort the operation with no done pulse; reset SHALL take priority over start in the same cycle.

Verification (NDIGITS=4)
REQ-028 Add: start, A=1234, B=5678, cin=0 -> done 5 cycles later, S=6912, Cout=0, invalid=0; busy high for 4 cycles.
REQ-029 Carry ripple: A=9999, B=0001, cin=0 -> S=0000, Cout=1; and A=0009, B=0000, cin=0 -> S=0009, Cout=0 (no correction at 9).
REQ-030 Subtract: sub=1, A=0005, B=0007, cin=0 -> S=9998, Cout=0; and sub=1, A=0100, B=0001, cin=1 -> S=0098, Cout=1.
REQ-031 Invalid: A=00A3, B=0001 -> invalid=1 at done and S per REQ-025; the next valid operation -> invalid=0.
REQ-032 Abort/ignore: reset asserted in the 2nd RUN cycle -> no done pulse and all outputs 0; start pulsed in RUN -> ignored, exactly one done pulse.
